// File: rtl/sram_bank_controller_pkg.sv
// sram_ctrl_pkg: shared types and helpers for the SRAM bank controller.
//   state_e  - controller FSM states (IDLE, ACCESS, ACK)
//   MAX_WAIT - largest supported WAIT_STATES value; sizes the wait counter
//   clog2    - elaboration-time ceil(log2(n)), used for index/counter widths
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam int MAX_WAIT = 15;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_bank_controller_if.sv
// sram_bus_if: 68k-side bus strobes plus SRAM-side strobes for one bank.
//   master - bus/test side: drives Address, SRamSelect_H, AS_L, UDS_L, LDS_L, WE_L
//   slave  - controller side: drives Block_H, SRam_UB_L/LB_L/OE_L/WE_L, Dtack_L
// With SRAM_BLOCK0_WRITE_PROTECT_EN defined, adds WrProtect_H (in) and
// WrViolation_H (out, sticky).
interface sram_bus_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int NUM_BLOCKS = 4
);
  logic [ADDR_WIDTH-1:0] Address;
  logic                  SRamSelect_H;
  logic                  AS_L;
  logic                  UDS_L;
  logic                  LDS_L;
  logic                  WE_L;
  logic [NUM_BLOCKS-1:0] Block_H;
  logic                  SRam_UB_L;
  logic                  SRam_LB_L;
  logic                  SRam_OE_L;
  logic                  SRam_WE_L;
  logic                  Dtack_L;
`ifdef SRAM_BLOCK0_WRITE_PROTECT_EN
  logic                  WrProtect_H;
  logic                  WrViolation_H;
`endif

  modport master (
    output Address, SRamSelect_H, AS_L, UDS_L, LDS_L, WE_L,
    input  Block_H, SRam_UB_L, SRam_LB_L, SRam_OE_L, SRam_WE_L, Dtack_L
`ifdef SRAM_BLOCK0_WRITE_PROTECT_EN
    , output WrProtect_H
    , input  WrViolation_H
`endif
  );

  modport slave (
    input  Address, SRamSelect_H, AS_L, UDS_L, LDS_L, WE_L,
    output Block_H, SRam_UB_L, SRam_LB_L, SRam_OE_L, SRam_WE_L, Dtack_L
`ifdef SRAM_BLOCK0_WRITE_PROTECT_EN
    , input  WrProtect_H
    , output WrViolation_H
`endif
  );

endinterface

// File: rtl/sram_bank_controller_onehot.sv
// sram_block_onehot: combinational binary-to-one-hot block decoder.
//   en_i     - when low the output is all zeros
//   idx_i    - block index, clog2(NUM_BLOCKS) bits
//   onehot_o - NUM_BLOCKS-wide one-hot select
module sram_block_onehot
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  localparam int BLK_BITS  = clog2(NUM_BLOCKS)
) (
  input  logic                  en_i,
  input  logic [BLK_BITS-1:0]   idx_i,
  output logic [NUM_BLOCKS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/sram_bank_controller.sv
// sram_bank_controller: 68k-to-SRAM bank controller.
//   Clock   - system clock
//   Reset_L - asynchronous active-low reset
//   bus     - sram_bus_if.slave: 68k strobes in, block select / SRAM strobes /
//             Dtack_L out (all outputs registered)
// Parameters: ADDR_WIDTH, NUM_BLOCKS (pow2, 2..16), WAIT_STATES (0..15).
// Optional: SRAM_BLOCK0_WRITE_PROTECT_EN adds block-0 write protection with a
// sticky WrViolation_H flag.
module sram_bank_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_BLOCKS  = 4,
  parameter int WAIT_STATES = 1
) (
  input logic       Clock,
  input logic       Reset_L,
  sram_bus_if.slave bus
);

  localparam int BLK_BITS = clog2(NUM_BLOCKS);
  localparam int CNT_W    = clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BLOCKS-1:0] blk_q, blk_d, blk_dec;
  logic                  ub_l_q, ub_l_d, lb_l_q, lb_l_d;
  logic                  oe_l_q, oe_l_d, we_l_q, we_l_d;
  logic                  dtack_l_q, dtack_l_d;
  logic                  start;
  logic                  wr_blocked;
  logic [BLK_BITS-1:0]   idx;

  assign idx   = bus.Address[ADDR_WIDTH-1 -: BLK_BITS];
  assign start = (state_q == IDLE) && !bus.AS_L && bus.SRamSelect_H &&
                 (!bus.UDS_L || !bus.LDS_L);

  sram_block_onehot #(.NUM_BLOCKS(NUM_BLOCKS)) u_dec (
    .en_i    (start),
    .idx_i   (idx),
    .onehot_o(blk_dec)
  );

`ifdef SRAM_BLOCK0_WRITE_PROTECT_EN
  logic viol_q;

  // Protected writes still run the full handshake; only the SRAM write
  // strobe is suppressed and the violation is remembered until reset.
  assign wr_blocked = !bus.WE_L && bus.WrProtect_H && (idx == '0);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L)                 viol_q <= 1'b0;
    else if (start && wr_blocked) viol_q <= 1'b1;
  end

  assign bus.WrViolation_H = viol_q;
`else
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    // Byte strobes can only drop once latched; a late re-assertion is ignored.
    ub_l_d  = ub_l_q | bus.UDS_L;
    lb_l_d  = lb_l_q | bus.LDS_L;
    oe_l_d  = oe_l_q;
    we_l_d  = we_l_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          cnt_d   = '0;
          blk_d   = blk_dec;
          ub_l_d  = bus.UDS_L;
          lb_l_d  = bus.LDS_L;
          oe_l_d  = !bus.WE_L;
          we_l_d  = bus.WE_L | wr_blocked;
        end
      end
      ACCESS: begin
        if (bus.AS_L)         state_d = IDLE;  // abort / bus error
        else if (cnt_q == WS) state_d = ACK;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ACK: begin
        if (bus.AS_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Everything is released on the same edge the FSM returns to IDLE.
    if (state_d == IDLE) begin
      cnt_d  = '0;
      blk_d  = '0;
      ub_l_d = 1'b1;
      lb_l_d = 1'b1;
      oe_l_d = 1'b1;
      we_l_d = 1'b1;
    end
    // Registered one clock behind entry to ACK, giving WAIT_STATES+2 latency.
    dtack_l_d = !((state_q == ACK) && (state_d == ACK));
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      blk_q     <= '0;
      ub_l_q    <= 1'b1;
      lb_l_q    <= 1'b1;
      oe_l_q    <= 1'b1;
      we_l_q    <= 1'b1;
      dtack_l_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      ub_l_q    <= ub_l_d;
      lb_l_q    <= lb_l_d;
      oe_l_q    <= oe_l_d;
      we_l_q    <= we_l_d;
      dtack_l_q <= dtack_l_d;
    end
  end

  assign bus.Block_H   = blk_q;
  assign bus.SRam_UB_L = ub_l_q;
  assign bus.SRam_LB_L = lb_l_q;
  assign bus.SRam_OE_L = oe_l_q;
  assign bus.SRam_WE_L = we_l_q;
  assign bus.Dtack_L   = dtack_l_q;

endmodule
